redirect_ctrl: RTL

Pipeline redirect and flush controller for the 5-stage LoongArch core. It collects redirect events: WB-stage exception entry (`wb_ex`), exception return (`wb_ertn`) and EX-stage branch taken. It prioritises them, emits flush pulses to the front stages, and holds the redirect PC until the instruction SRAM accepts a fetch request to it. It also tracks outstanding fetch requests, so wrong-path responses already in flight are discarded before the IF stage accepts any new data.

---
 rtl/core_pkg.sv | 19 +
 rtl/fetch_inflight_cnt.sv | 26 ++
 rtl/redirect_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types for the front-end redirect logic: FSM state, event-select
// encoding and the default outstanding-fetch counter width.
package core_pkg;

  localparam int OUTST_W_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EX   = 2'd1,
    EV_ERTN = 2'd2,
    EV_BR   = 2'd3
  } ev_sel_e;

endpackage

// File: rtl/fetch_inflight_cnt.sv
// Up/down counter of instruction fetches accepted by the SRAM but not yet answered.
// Callers must never increment when full or decrement at zero.
module fetch_inflight_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         full
);

  logic [W-1:0] count_q;

  assign count_next = count_q + W'(inc) - W'(dec);
  assign count      = count_q;
  assign full       = &count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_next;
  end

endmodule

// File: rtl/redirect_ctrl.sv
// Redirect/flush controller: prioritises WB exception, ERTN and EX branch events,
// holds the redirect PC until fetched, and discards wrong-path fetch responses.
module redirect_ctrl
  import core_pkg::*;
#(
  parameter int OUTST_W = OUTST_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_ex,
  input  logic        wb_ertn,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        fs_req_ok,
  input  logic        fs_resp_ok,
  output logic        flush_all,
  output logic        flush_front,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        discard_resp,
  output logic        fetch_block,
  output logic        busy
);

  rd_state_e          state_q;
  logic [31:0]        redirect_pc_q;
  logic [OUTST_W-1:0] cancel_q, cancel_d;
  logic [OUTST_W-1:0] inflight, inflight_next;
  logic               inflight_full;
  ev_sel_e            ev_sel;
  logic [31:0]        ev_target;
  logic               ev_any;

  fetch_inflight_cnt #(.W(OUTST_W)) u_inflight (
    .clk        (clk),
    .reset      (reset),
    .inc        (fs_req_ok),
    .dec        (fs_resp_ok),
    .count      (inflight),
    .count_next (inflight_next),
    .full       (inflight_full)
  );

  // A branch seen during HOLD comes from an already-flushed stage and is dropped.
  always_comb begin
    ev_sel    = EV_NONE;
    ev_target = '0;
    if (wb_ex) begin
      ev_sel    = EV_EX;
      ev_target = csr_eentry;
    end else if (wb_ertn) begin
      ev_sel    = EV_ERTN;
      ev_target = csr_era;
    end else if (br_taken && state_q == IDLE) begin
      ev_sel    = EV_BR;
      ev_target = br_target;
    end
  end

  assign ev_any      = (ev_sel != EV_NONE);
  assign flush_all   = (ev_sel == EV_EX) || (ev_sel == EV_ERTN);
  assign flush_front = (ev_sel == EV_BR);

  assign discard_resp = (cancel_q != '0) && fs_resp_ok;

  // Everything already accepted (including this cycle's request) is wrong-path.
  always_comb begin
    cancel_d = cancel_q;
    if (ev_any)            cancel_d = inflight_next;
    else if (discard_resp) cancel_d = cancel_q - OUTST_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
      cancel_q      <= '0;
    end else begin
      cancel_q <= cancel_d;
      case (state_q)
        IDLE: begin
          if (ev_any) begin
            state_q       <= HOLD;
            redirect_pc_q <= ev_target;
          end
        end
        HOLD: begin
          // A new WB event re-arms HOLD; a request issued this cycle went to the old PC.
          if (ev_any)         redirect_pc_q <= ev_target;
          else if (fs_req_ok) state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign redirect_valid = (state_q == HOLD);
  assign redirect_pc    = redirect_pc_q;
  assign fetch_block    = inflight_full;
  assign busy           = (state_q == HOLD) || (cancel_q != '0);

endmodule
